// File: rtl/tt_scan_pkg.sv
// Shared types and constants for the Tiny Tapeout scan-chain host controller.
package tt_scan_pkg;

  localparam int unsigned BYTE_W       = 8;
  localparam int unsigned LATCH_CYCLES = 2;

  typedef enum logic [2:0] {
    StIdle,
    StShiftIn,
    StLatch,
    StWait,
    StCapture,
    StShiftOut,
    StResp
  } scan_state_e;

  typedef enum logic {
    PhLow  = 1'b0,
    PhHigh = 1'b1
  } scan_phase_e;

endpackage

// File: rtl/tt_scan_shifter.sv
// Serial engine: parallel-load transmit register, serial-in receive register,
// scan_clk phase toggle and bit counter.
module tt_scan_shifter
  import tt_scan_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [N-1:0] i_load_data,
  input  logic         i_shift_en,
  input  logic         i_capture,
  input  logic         i_rx_en,
  input  logic         i_sdi,
  output logic         o_sclk,
  output logic         o_sdo,
  output logic [N-1:0] o_rx_next,
  output logic         o_done
);

  localparam int unsigned CNT_W = $clog2(N);

  scan_phase_e      r_phase;
  logic [N-1:0]     r_tx;
  logic [N-1:0]     r_rx;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             w_fall;

  // End of a high phase: data launches and the tail is sampled here.
  assign w_fall    = i_shift_en && (r_phase == PhHigh);
  assign o_sclk    = (r_phase == PhHigh);
  assign o_sdo     = r_tx[N-1];
  assign o_rx_next = {r_rx[N-2:0], i_sdi};
  assign o_done    = w_fall && (r_bit_cnt == CNT_W'(N - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phase   <= PhLow;
      r_tx      <= '0;
      r_rx      <= '0;
      r_bit_cnt <= '0;
    end else begin
      if (i_shift_en || i_capture) begin
        r_phase <= (r_phase == PhLow) ? PhHigh : PhLow;
      end else begin
        r_phase <= PhLow;
      end

      if (i_load) begin
        r_tx <= i_load_data;
      end else if (w_fall) begin
        r_tx <= {r_tx[N-2:0], 1'b0};
      end

      if (w_fall && i_rx_en) begin
        r_rx <= o_rx_next;
      end

      if (!i_shift_en) begin
        r_bit_cnt <= '0;
      end else if (w_fall) begin
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/tt_scan_controller.sv
// Host-side scan-chain driver: shifts one request byte into a design slot, latches,
// settles, captures all outputs, shifts them back and returns the selected byte.
module tt_scan_controller
  import tt_scan_pkg::*;
#(
  parameter int unsigned NUM_DESIGNS = 2,
  parameter int unsigned SEL_W       = 4,
  parameter int unsigned WAIT_CYCLES = 4
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [SEL_W-1:0]  req_sel,
  input  logic [BYTE_W-1:0] req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [BYTE_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              scan_clk,
  output logic              scan_data_out,
  input  logic              scan_data_in,
  output logic              scan_select,
  output logic              scan_latch_en
);

  localparam int unsigned N     = BYTE_W * NUM_DESIGNS;
  localparam int unsigned CNT_W = $clog2(WAIT_CYCLES + LATCH_CYCLES);

  scan_state_e       r_state;
  scan_state_e       w_state_d;
  logic [SEL_W-1:0]  r_sel;
  logic              r_err;
  logic [BYTE_W-1:0] r_rsp_data;
  logic [CNT_W-1:0]  r_wait_cnt;

  logic              w_accept;
  logic              w_err_in;
  logic [N-1:0]      w_load_vec;
  logic [N-1:0]      w_rx_next;
  logic [BYTE_W-1:0] w_rsp_next;
  logic              w_done;
  logic              w_sclk;
  logic              w_shift_en;

  assign w_accept   = req_valid && (r_state == StIdle);
  assign w_shift_en = (r_state == StShiftIn) || (r_state == StShiftOut);

  // Out-of-range selects match no slot, giving an all-zero vector and a zero response.
  always_comb begin
    w_err_in   = 1'b1;
    w_load_vec = '0;
    w_rsp_next = '0;
    for (int unsigned d = 0; d < NUM_DESIGNS; d++) begin
      if (req_sel == SEL_W'(d)) begin
        w_err_in                       = 1'b0;
        w_load_vec[d*BYTE_W +: BYTE_W] = req_data;
      end
      if (r_sel == SEL_W'(d)) begin
        w_rsp_next = w_rx_next[d*BYTE_W +: BYTE_W];
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:     if (req_valid) w_state_d = StShiftIn;
      StShiftIn:  if (w_done) w_state_d = StLatch;
      StLatch:    if (r_wait_cnt == CNT_W'(LATCH_CYCLES - 1)) w_state_d = StWait;
      StWait:     if (r_wait_cnt == CNT_W'(WAIT_CYCLES - 1)) w_state_d = StCapture;
      StCapture:  if (w_sclk) w_state_d = StShiftOut;
      StShiftOut: if (w_done) w_state_d = StResp;
      StResp:     if (rsp_ready) w_state_d = StIdle;
      default:    w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state    <= StIdle;
      r_sel      <= '0;
      r_err      <= 1'b0;
      r_rsp_data <= '0;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_sel <= req_sel;
        r_err <= w_err_in;
      end
      // The final chain bit arrives on the same edge as done, so use the next-state view.
      if ((r_state == StShiftOut) && w_done) begin
        r_rsp_data <= w_rsp_next;
      end
      if (w_state_d != r_state) begin
        r_wait_cnt <= '0;
      end else if ((r_state == StLatch) || (r_state == StWait)) begin
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      end
    end
  end

  tt_scan_shifter #(
    .N (N)
  ) u_shifter (
    .i_clk       (wb_clk_i),
    .i_rst_n     (wb_rst_ni),
    .i_load      (w_accept),
    .i_load_data (w_load_vec),
    .i_shift_en  (w_shift_en),
    .i_capture   (r_state == StCapture),
    .i_rx_en     (r_state == StShiftOut),
    .i_sdi       (scan_data_in),
    .o_sclk      (w_sclk),
    .o_sdo       (scan_data_out),
    .o_rx_next   (w_rx_next),
    .o_done      (w_done)
  );

  assign req_ready     = (r_state == StIdle);
  assign rsp_valid     = (r_state == StResp);
  assign rsp_data      = r_rsp_data;
  assign rsp_err       = r_err;
  assign scan_clk      = w_sclk;
  assign scan_select   = (r_state == StCapture);
  assign scan_latch_en = (r_state == StLatch);

endmodule

// File: tb/tb_tt_scan_controller.sv
// Directed bench for tt_scan_controller with a behavioural two-design scan chain:
// design0 io_out = ~io_in, design1 io_out = io_in + 1.
module tb_tt_scan_controller;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       req_valid = 1'b0;
  logic       rsp_ready = 1'b0;
  logic [3:0] req_sel   = '0;
  logic [7:0] req_data  = '0;
  logic       req_ready, rsp_valid, rsp_err;
  logic [7:0] rsp_data;
  logic       scan_clk, scan_data_out, scan_data_in, scan_select, scan_latch_en;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int lat;
  int n;
  int acc [3];
  logic [15:0] tx;
  int          nbits;

  logic [15:0] chain   = '0;
  logic [15:0] io_in_m = '0;
  logic [15:0] io_out_m;
  logic        tail_q  = 1'b0;

  logic [3:0] bs [3] = '{4'd1, 4'd0, 4'd1};
  logic [7:0] bd [3] = '{8'h10, 8'hAA, 8'hFF};
  logic [7:0] be [3] = '{8'h11, 8'h55, 8'h00};

  tt_scan_controller #(
    .NUM_DESIGNS (2),
    .SEL_W       (4),
    .WAIT_CYCLES (4)
  ) dut (
    .wb_clk_i      (clk),
    .wb_rst_ni     (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_sel       (req_sel),
    .req_data      (req_data),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_err       (rsp_err),
    .scan_clk      (scan_clk),
    .scan_data_out (scan_data_out),
    .scan_data_in  (scan_data_in),
    .scan_select   (scan_select),
    .scan_latch_en (scan_latch_en)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Chain model; the tail bit is registered so it holds through the high phase.
  assign io_out_m     = {io_in_m[15:8] + 8'd1, ~io_in_m[7:0]};
  assign scan_data_in = tail_q;
  always @(posedge scan_clk) begin
    tail_q <= chain[15];
    if (scan_select) chain <= io_out_m;
    else             chain <= {chain[14:0], scan_data_out};
  end
  always @(posedge clk) if (scan_latch_en) io_in_m <= chain;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_scan_clk"}, scan_clk, 0);
    chk({tag, "_scan_data_out"}, scan_data_out, 0);
    chk({tag, "_scan_select"}, scan_select, 0);
    chk({tag, "_scan_latch_en"}, scan_latch_en, 0);
  endtask

  // Counts cycles from the accept edge to rsp_valid, recording transmitted bits.
  task automatic wait_rsp(output int l);
    l = 0;
    do begin
      step();
      l++;
      if (scan_clk && !scan_select && nbits < 16) begin
        tx = {tx[14:0], scan_data_out};
        nbits++;
      end
    end while (!rsp_valid && l < 200);
  endtask

  task automatic issue(input logic [3:0] s, input logic [7:0] d);
    req_sel   = s;
    req_data  = d;
    req_valid = 1'b1;
    tx        = '0;
    nbits     = 0;
    step();
    req_valid = 1'b0;
    chk("accept", req_ready, 0);
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) step();
    chk_reset("rst");
    rst_n = 1'b1;
    step();

    // sel=1 data=0x41, then hold the response with a pending request.
    issue(4'd1, 8'h41);
    wait_rsp(lat);
    chk("t1_latency", lat, 72);
    chk("t1_rsp_data", rsp_data, 8'h42);
    chk("t1_rsp_err", rsp_err, 0);
    chk("t1_io_in_d0", io_in_m[7:0], 8'h00);
    chk("t1_io_in_d1", io_in_m[15:8], 8'h41);
    req_sel   = 4'd0;
    req_data  = 8'h0F;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_rsp_data", rsp_data, 8'h42);
      chk("hold_req_ready", req_ready, 0);
    end
    take_rsp();
    chk("hold_ready_back", req_ready, 1);
    chk("hold_valid_drop", rsp_valid, 0);

    // Pending request (sel=0 data=0x0F) is accepted on this edge.
    tx    = '0;
    nbits = 0;
    step();
    req_valid = 1'b0;
    chk("t2_accept", req_ready, 0);
    wait_rsp(lat);
    chk("t2_latency", lat, 72);
    chk("t2_rsp_data", rsp_data, 8'hF0);
    chk("t2_rsp_err", rsp_err, 0);
    chk("t2_tx_order", tx, 16'h000F);
    take_rsp();

    // Out-of-range select.
    issue(4'd3, 8'h5A);
    wait_rsp(lat);
    chk("t3_latency", lat, 72);
    chk("t3_rsp_err", rsp_err, 1);
    chk("t3_rsp_data", rsp_data, 8'h00);
    chk("t3_io_in", io_in_m, 16'h0000);
    take_rsp();

    // Reset in the middle of SHIFT_OUT.
    issue(4'd1, 8'h33);
    repeat (49) step();
    chk("t4_busy", req_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    step();
    rst_n = 1'b1;
    step();
    issue(4'd1, 8'h7F);
    wait_rsp(lat);
    chk("t4_latency", lat, 72);
    chk("t4_rsp_data", rsp_data, 8'h80);
    take_rsp();

    // Back-to-back with rsp_ready tied high.
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_sel   = bs[k];
      req_data  = bd[k];
      req_valid = 1'b1;
      n = 0;
      do begin
        step();
        n++;
      end while (req_ready && n < 200);
      acc[k] = cyc;
      if (k == 2) req_valid = 1'b0;
      nbits = 16;
      wait_rsp(lat);
      chk("b2b_latency", lat, 72);
      chk("b2b_rsp_data", rsp_data, be[k]);
      if (k > 0) chk("b2b_spacing", acc[k] - acc[k-1], 74);
    end
    req_valid = 1'b0;
    step();
    rsp_ready = 1'b0;
    step();
    chk("end_idle", req_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tt_scan_controller.md
# tt_scan_controller

Host-side driver for the Tiny Tapeout style scan chain of 8-in/8-out user designs inside `user_project_wrapper`. It takes a request (design index and 8-bit input word) and shifts the word into that design's slot. It then latches it onto the design's `io_in[7:0]`, waits a settle time, captures every design's `io_out[7:0]` and shifts the chain out. Finally it returns the selected design's output byte over a valid/ready response.

## Interface
Parameters:
- `NUM_DESIGNS`, 2: number of 8-bit chain stages; N = 8*NUM_DESIGNS chain bits.
- `SEL_W`, 4: width of `req_sel`.
- `WAIT_CYCLES`, 4: settle cycles between latch and capture; minimum 1.

Ports:
- `wb_clk_i`  in  1  sole clock.
- `wb_rst_ni`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high in IDLE only.
- `req_sel`  in  SEL_W  target design index.
- `req_data`  in  8  byte to apply to target `io_in`.
- `rsp_valid`  out  1  response held until accepted.
- `rsp_ready`  in  1  response accept.
- `rsp_data`  out  8  captured target `io_out`.
- `rsp_err`  out  1  `req_sel` ≥ NUM_DESIGNS.
- `scan_clk`  out  1  chain shift clock, wb_clk_i/2.
- `scan_data_out`  out  1  serial data into chain head.
- `scan_data_in`  in  1  serial data from chain tail.
- `scan_select`  out  1  capture-mode select.
- `scan_latch_en`  out  1  transfer shift regs to design inputs.

## Operation
- Chain model:
  - Chain vector V[N-1:0]; design d owns V[8d+7:8d], with bit i = that design's `io_in[i]` / `io_out[i]`.
  - Transmission is MSB first: V[N-1] is shifted first.
  - Reception is also MSB first: the first bit from `scan_data_in` is V[N-1].
- Outgoing vector: slot `req_sel` = `req_data`; all other slots 0.
  - If `req_sel` ≥ NUM_DESIGNS, every slot is 0 and `rsp_err`=1 is flagged.
- FSM states and transitions:
  - IDLE: `req_ready`=1. The accept edge (`req_valid`&&`req_ready`) registers sel/data, loads V and goes to SHIFT_IN.
  - SHIFT_IN: 2N cycles, then LATCH.
  - LATCH: `scan_latch_en`=1 for 2 cycles, then WAIT.
  - WAIT: WAIT_CYCLES cycles, then CAPTURE.
  - CAPTURE: `scan_select`=1 for 2 cycles, with one `scan_clk` high phase inside; then SHIFT_OUT.
  - SHIFT_OUT: 2N cycles, then RESP.
  - RESP: `rsp_valid`=1. The edge with `rsp_ready` returns to IDLE.
- Bit timing, SHIFT_IN and SHIFT_OUT:
  - Each bit occupies 2 cycles: a low phase, then a high phase of `scan_clk`.
  - `scan_data_out` changes only on the edge that drives `scan_clk` low.
  - `scan_data_in` is sampled on the edge that drives `scan_clk` low (end of the high phase).
- `rsp_data`/`rsp_err` are stable throughout RESP. `rsp_data` = received R[8*sel+7:8*sel]; it is 0 when `rsp_err`=1.
- Outside SHIFT/CAPTURE, `scan_clk`=0. `scan_select` and `scan_latch_en` are never high simultaneously.
- Reset (async assert, any state, including mid-shift):
  - FSM goes to IDLE; all shift registers and counters clear.
  - Outputs: `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `scan_clk`=0, `scan_data_out`=0, `scan_select`=0, `scan_latch_en`=0, `req_ready`=1.
  - The chain contents are undefined after reset; the next request fully rewrites them.

## Timing
- Latency: `rsp_valid` rises exactly 4N+WAIT_CYCLES+4 cycles after the accept edge; defaults give 72.
- Throughput: `req_ready` returns 1 the cycle after the `rsp_valid`&&`rsp_ready` edge. A request presented then is accepted on the next edge, so the minimum request spacing is latency+2.
- `req_valid` while busy is ignored, not queued. `req_*` are sampled only on the accept edge.
- `rsp_ready` held high is accepted on the first RESP cycle, giving a 1-cycle `rsp_valid` pulse.

## Structure
- Package `tt_scan_pkg` holds:
  - the state enum (IDLE, SHIFT_IN, LATCH, WAIT, CAPTURE, SHIFT_OUT, RESP);
  - constants BYTE_W=8 and the scan-phase encodings.
- Sub-module `tt_scan_shifter` holds:
  - the N-bit parallel-load/serial-out register and the serial-in register;
  - the bit counter and the `scan_clk` phase toggle;
  - `done` strobes for the FSM.
- The top level keeps the FSM, the wait counter, slot insert/extract and the response register.

## Test plan
The bench uses a behavioural chain model with NUM_DESIGNS=2: design0 `io_out`=~`io_in`, design1 `io_out`=`io_in`+1.
- Request sel=1, data=0x41 → `rsp_data`=0x42, `rsp_err`=0, `rsp_valid` exactly 72 cycles after accept; model shows design0 `io_in`=0x00.
- Request sel=0, data=0x0F → `rsp_data`=0xF0. Check `scan_data_out` bit order: the slot1 zeros go first, then 0,0,0,0,1,1,1,1.
- Request sel=3 → `rsp_err`=1, `rsp_data`=0x00; both model design inputs are 0x00.
- Hold `rsp_ready`=0 for 5 RESP cycles → `rsp_valid` and `rsp_data` are stable, and a `req_valid` asserted during that time is not accepted until after the response is taken.
- Assert `wb_rst_ni`=0 mid-SHIFT_OUT (cycle 50) → all outputs take their reset values asynchronously. After release, a request sel=1 data=0x7F returns 0x80.
- Back-to-back: 3 requests with `rsp_ready` tied high → each returns correct data, with exactly 74-cycle spacing between accepts.
